dht11_responder: RTL
====================

DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 The block SHALL have parameter TICKS_PER_US, default 100, meaning clk cycles per microsecond (100 MHz clk).
REQ-002 The block SHALL have parameter START_MIN_US, default 10000, meaning the minimum host low time accepted as a start request, in us.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port data_in, input, 1, the sampled level of the single-wire bus, which has an external pull-up.
REQ-006 The block SHALL have port drive_low, output, 1.
- 1 = pull the bus low.
- 0 = release the bus (top level ties the pad to open-drain).
REQ-007 The block SHALL have port hum, input, 8, the humidity integer byte to report.
REQ-008 The block SHALL have port temp, input, 8, the temperature integer byte to report.
REQ-009 The block SHALL have port busy, output, 1, high from start acceptance to end of frame.
REQ-010 The block SHALL have port frame_done, output, 1, a one-cycle pulse when a frame completes.

Function
REQ-011 data_in SHALL pass through a 2-FF synchronizer; all timing SHALL be measured on the synchronized level.
REQ-012 A us-tick prescaler SHALL count 0..TICKS_PER_US-1; every duration below is a whole number of ticks, with tolerance ±3 clk.
REQ-013 States SHALL be IDLE, START_LOW, WAIT_RELEASE, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-014 The IDLE and START_LOW transitions SHALL be as follows.
- IDLE: on a synchronized low, go to START_LOW and clear the us counter.
- START_LOW: if the line returns high before START_MIN_US, go to IDLE with no response.
- START_LOW: at START_MIN_US, go to WAIT_RELEASE.
REQ-015 WAIT_RELEASE SHALL wait for the line high with no timeout.
- On release, latch hum and temp into a 40-bit shift register.
- Shift-register order: {hum, 8'h00, temp, 8'h00, checksum}.
- checksum = (hum + temp) mod 256, 8-bit wrap.
- Assert busy, then go to RESP_DELAY.
REQ-016 The response SHALL be the following sequence.
- RESP_DELAY: released for 30 us.
- RESP_LOW: drive low for 80 us.
- RESP_HIGH: released for 80 us.
REQ-017 Each of the 40 bits SHALL be sent MSB first.
- BIT_LOW: drive low for 50 us.
- BIT_HIGH: released for 26 us for a 0 bit, or 70 us for a 1 bit.
- A 6-bit counter SHALL count bits 0..39.
REQ-018 After bit 39, END_LOW SHALL drive low for 50 us and then release.
- At the release: pulse frame_done for one cycle, deassert busy in the same cycle, and go to IDLE.
REQ-019 From RESP_DELAY through END_LOW, data_in SHALL be ignored; host activity SHALL NOT abort or extend the frame.
REQ-020 The next start SHALL be detected only from IDLE; a low already present on IDLE entry counts as a start from that cycle.
REQ-021 drive_low SHALL be registered and high only in RESP_LOW, BIT_LOW and END_LOW.
REQ-022 hum and temp changes after the latch SHALL NOT affect the frame in progress.

Reset
REQ-023 Asserting rst low SHALL asynchronously force the following values.
- State = IDLE.
- drive_low = 0, busy = 0, frame_done = 0.
- Prescaler, counters, shift register and synchronizer all 0.
REQ-024 Reset mid-frame SHALL release the bus immediately and discard the frame.
- After deassertion, the block SHALL accept a new start only after a fresh full START_MIN_US low.

Configuration
REQ-025 The macro DHT11_ERR_INJECT_EN SHALL control checksum error injection.
- Defined: an extra input port err_inject (1 bit) is present; when err_inject = 1 at the latch cycle, the transmitted checksum is ((hum + temp) mod 256) XOR 8'h01.
- Undefined: the port is absent and the checksum is always correct.

Verification
REQ-026 The bench SHALL cover a full frame.
- Stimulus: TICKS_PER_US = 100, hum = 8'h2D, temp = 8'h17, host low for 18 ms, then release.
- Response: low at 30 us (80 us low), 80 us high, then 40 bits encoding 2D 00 17 00 44, then 50 us low.
- frame_done fires once; busy is high for the whole frame.
REQ-027 The bench SHALL cover a short start.
- Stimulus: host low for 5 ms, then release.
- Response: drive_low stays 0, busy stays 0, state returns to IDLE.
REQ-028 The bench SHALL cover checksum wrap.
- Stimulus: hum = 8'hC8, temp = 8'h64.
- Response: checksum byte 8'h2C.
- Bit-high widths are 70 us for 1 bits and 26 us for 0 bits, ±3 clk.
REQ-029 The bench SHALL cover reset mid-frame.
- Stimulus: assert rst low during bit 12 (in BIT_LOW).
- Response: drive_low = 0 within the same cycle, busy = 0, and no frame_done.
- A later 18 ms start yields a complete correct frame.
REQ-030 The bench SHALL cover host interference.
- Stimulus: host pulses the line low for 10 us during RESP_HIGH.
- Response: frame timing is unchanged and all 40 bits are correct.
REQ-031 The bench SHALL cover error injection.
- Stimulus: DHT11_ERR_INJECT_EN defined, err_inject = 1, hum = 8'h2D, temp = 8'h17.
- Response: checksum byte 8'h45.

Source files
------------

// File: rtl/dht11_responder.sv
// DHT11-compatible single-wire sensor emulator: answers a host start pulse with a 40-bit humidity/temperature frame.
// Optional build macro DHT11_ERR_INJECT_EN adds err_inject, which flips the checksum LSB of the latched frame.
module dht11_responder #(
    parameter int unsigned TICKS_PER_US = 100,
    parameter int unsigned START_MIN_US = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic       drive_low,
    input  logic [7:0] hum,
    input  logic [7:0] temp,
`ifdef DHT11_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned PS_W       = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int unsigned US_W       = $clog2(START_MIN_US + 128);
    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned BIT_W      = 6;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_RELEASE,
        RESP_DELAY,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    logic [PS_W-1:0]         ps_q, ps_d;
    logic [US_W-1:0]         us_q, us_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    drive_low_q, drive_low_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    line_c;
    logic                    tick_c;
    logic                    done_c;
    logic [US_W-1:0]         dur_c;
    logic [7:0]              csum_c;

    assign line_c = sync_q[1];
    assign tick_c = (ps_q == PS_W'(TICKS_PER_US - 1));
    assign done_c = tick_c && (us_q == dur_c - US_W'(1));

    // Checksum of the bytes being latched, optionally corrupted for host error-path testing
    always_comb begin
        csum_c = hum + temp;
`ifdef DHT11_ERR_INJECT_EN
        csum_c = csum_c ^ {7'd0, err_inject};
`endif
    end

    // Length in microseconds of the current timed phase
    always_comb begin
        dur_c = US_W'(1);
        unique case (state_q)
            START_LOW:  dur_c = US_W'(START_MIN_US);
            RESP_DELAY: dur_c = US_W'(30);
            RESP_LOW:   dur_c = US_W'(80);
            RESP_HIGH:  dur_c = US_W'(80);
            BIT_LOW:    dur_c = US_W'(50);
            BIT_HIGH:   dur_c = shift_q[FRAME_BITS-1] ? US_W'(70) : US_W'(26);
            END_LOW:    dur_c = US_W'(50);
            default:    dur_c = US_W'(1);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ps_d         = tick_c ? '0 : ps_q + PS_W'(1);
        us_d         = tick_c ? us_q + US_W'(1) : us_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!line_c) state_d = START_LOW;
            end
            START_LOW: begin
                if (line_c)      state_d = IDLE;
                else if (done_c) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (line_c) begin
                    shift_d = {hum, 8'h00, temp, 8'h00, csum_c};
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RESP_DELAY;
                end
            end
            RESP_DELAY: if (done_c) state_d = RESP_LOW;
            RESP_LOW:   if (done_c) state_d = RESP_HIGH;
            RESP_HIGH:  if (done_c) state_d = BIT_LOW;
            BIT_LOW:    if (done_c) state_d = BIT_HIGH;
            BIT_HIGH: begin
                if (done_c) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = END_LOW;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = BIT_LOW;
                    end
                end
            end
            END_LOW: begin
                if (done_c) begin
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every phase starts timing from a fresh microsecond boundary
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_RELEASE)) begin
            ps_d = '0;
            us_d = '0;
        end

        drive_low_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            ps_q         <= '0;
            us_q         <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            drive_low_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], data_in};
            ps_q         <= ps_d;
            us_q         <= us_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            drive_low_q  <= drive_low_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign drive_low  = drive_low_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
